denetim_durum_birimi: RTL and testbench

Pipeline hazard and stall/flush controller (Denetim Durum Birimi) for the five-stage core. It drives the stall, flush and forwarding-select inputs of GETIR, COZ_YAZMACOKU and YURUT. It sequences load-use bubbles, multi-cycle YURUT operations (DIV/REM/MUL, CONV_RUN) and memory waits, and counts stall cycles for performance monitoring.

---
 rtl/denetim_durum_birimi_if.sv | 57 +++++
 rtl/denetim_durum_birimi.sv | 138 +++++++++++++
 tb/tb_denetim_durum_birimi.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/denetim_durum_birimi_if.sv
// Hazard-control bundle between the five-stage pipeline and denetim_durum_birimi.
//   slave  : the controller (reads hazard info, drives stall/flush/forward selects)
//   master : the pipeline side (drives hazard info, consumes the controls)
// Signal names keep the pipeline's _i/_o suffixes as seen from the controller.
interface denetim_durum_birimi_if;
  // COZ stage operands
  logic [4:0]  coz_rs1_adres_i;
  logic [4:0]  coz_rs2_adres_i;
  logic        coz_rs1_kullan_i;
  logic        coz_rs2_kullan_i;
  // YURUT / GERIYAZ destinations
  logic [4:0]  yrt_rd_adres_i;
  logic        yrt_yaz_yazmac_i;
  logic        yrt_bellek_oku_i;
  logic [4:0]  gy_rd_adres_i;
  logic        gy_yaz_yazmac_i;
  // Events
  logic        yrt_cok_cevrim_basla_i;
  logic        yrt_cok_cevrim_bitti_i;
  logic        yrt_atlama_i;
  logic        bellek_bekle_i;
  // Controls back to the pipeline
  logic        gtr_durdur_o;
  logic        coz_durdur_o;
  logic        yrt_durdur_o;
  logic        gtr_bosalt_o;
  logic        coz_bosalt_o;
  logic        yrt_bosalt_o;
  logic [1:0]  yonlendir_kontrol1_o;
  logic [1:0]  yonlendir_kontrol2_o;
  // Status
  logic [1:0]  durum_o;
  logic        zaman_asimi_o;
  logic [31:0] durdur_sayac_o;

  modport slave (
    input  coz_rs1_adres_i, coz_rs2_adres_i, coz_rs1_kullan_i, coz_rs2_kullan_i,
           yrt_rd_adres_i, yrt_yaz_yazmac_i, yrt_bellek_oku_i,
           gy_rd_adres_i, gy_yaz_yazmac_i,
           yrt_cok_cevrim_basla_i, yrt_cok_cevrim_bitti_i, yrt_atlama_i, bellek_bekle_i,
    output gtr_durdur_o, coz_durdur_o, yrt_durdur_o,
           gtr_bosalt_o, coz_bosalt_o, yrt_bosalt_o,
           yonlendir_kontrol1_o, yonlendir_kontrol2_o,
           durum_o, zaman_asimi_o, durdur_sayac_o
  );

  modport master (
    output coz_rs1_adres_i, coz_rs2_adres_i, coz_rs1_kullan_i, coz_rs2_kullan_i,
           yrt_rd_adres_i, yrt_yaz_yazmac_i, yrt_bellek_oku_i,
           gy_rd_adres_i, gy_yaz_yazmac_i,
           yrt_cok_cevrim_basla_i, yrt_cok_cevrim_bitti_i, yrt_atlama_i, bellek_bekle_i,
    input  gtr_durdur_o, coz_durdur_o, yrt_durdur_o,
           gtr_bosalt_o, coz_bosalt_o, yrt_bosalt_o,
           yonlendir_kontrol1_o, yonlendir_kontrol2_o,
           durum_o, zaman_asimi_o, durdur_sayac_o
  );
endinterface

// File: rtl/denetim_durum_birimi.sv
// Denetim Durum Birimi: hazard, stall and flush controller of the five-stage core.
// Ports:
//   clk_i  - core clock
//   rst_ni - asynchronous active-low reset
//   bus    - denetim_durum_birimi_if.slave: hazard inputs, stall/flush/forward
//            controls (combinational), state / timeout flag / stall counter (registered)
// Parameter:
//   ZAMAN_ASIMI - cycles allowed in COK_CEVRIM before a forced exit (2..255)
module denetim_durum_birimi #(
  parameter int unsigned ZAMAN_ASIMI = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  denetim_durum_birimi_if.slave       bus
);

  typedef enum logic [1:0] {
    CALIS      = 2'b00,
    YUK_BEKLE  = 2'b01,
    COK_CEVRIM = 2'b10
  } durum_t;

  localparam logic [7:0] SON_SAYI = 8'(ZAMAN_ASIMI - 1);

  durum_t      durum_q, durum_d;
  logic [7:0]  zs_q;
  logic        zs_sifirla, zs_artir, zaman_kur;
  logic        zaman_asimi_q;
  logic [31:0] durdur_sayac_q;
  logic        yu;
  logic        gtr_durdur, coz_durdur, yrt_durdur;
  logic        gtr_bosalt, coz_bosalt, yrt_bosalt;

  // A load in YURUT cannot forward yet; its value is taken from GERIYAZ next cycle.
  function automatic logic [1:0] yonlendir(
    input logic [4:0] rs,
    input logic [4:0] yrt_rd, input logic yrt_yaz, input logic yrt_oku,
    input logic [4:0] gy_rd,  input logic gy_yaz
  );
    if (yrt_yaz && (yrt_rd != 5'd0) && (yrt_rd == rs) && !yrt_oku) return 2'b01;
    if (gy_yaz && (gy_rd != 5'd0) && (gy_rd == rs))                 return 2'b10;
    return 2'b00;
  endfunction

  assign bus.yonlendir_kontrol1_o = yonlendir(bus.coz_rs1_adres_i,
      bus.yrt_rd_adres_i, bus.yrt_yaz_yazmac_i, bus.yrt_bellek_oku_i,
      bus.gy_rd_adres_i, bus.gy_yaz_yazmac_i);
  assign bus.yonlendir_kontrol2_o = yonlendir(bus.coz_rs2_adres_i,
      bus.yrt_rd_adres_i, bus.yrt_yaz_yazmac_i, bus.yrt_bellek_oku_i,
      bus.gy_rd_adres_i, bus.gy_yaz_yazmac_i);

  assign yu = bus.yrt_bellek_oku_i && bus.yrt_yaz_yazmac_i && (bus.yrt_rd_adres_i != 5'd0) &&
              ((bus.coz_rs1_kullan_i && (bus.yrt_rd_adres_i == bus.coz_rs1_adres_i)) ||
               (bus.coz_rs2_kullan_i && (bus.yrt_rd_adres_i == bus.coz_rs2_adres_i)));

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves one
    // unassigned; otherwise synthesis would infer a latch.
    durum_d    = durum_q;
    gtr_durdur = 1'b0;
    coz_durdur = 1'b0;
    yrt_durdur = 1'b0;
    gtr_bosalt = 1'b0;
    coz_bosalt = 1'b0;
    yrt_bosalt = 1'b0;
    zs_sifirla = 1'b0;
    zs_artir   = 1'b0;
    zaman_kur  = 1'b0;

    if (bus.bellek_bekle_i) begin
      // Memory wait freezes everything; a bitti arriving now is held by YURUT.
      gtr_durdur = 1'b1;
      coz_durdur = 1'b1;
      yrt_durdur = 1'b1;
    end else begin
      gtr_bosalt = bus.yrt_atlama_i;
      coz_bosalt = bus.yrt_atlama_i;
      unique case (durum_q)
        CALIS: begin
          if (bus.yrt_cok_cevrim_basla_i) begin
            durum_d    = COK_CEVRIM;
            zs_sifirla = 1'b1;
          end else if (yu && !bus.yrt_atlama_i) begin
            // The flushed path would make the bubble pointless, so a jump wins.
            gtr_durdur = 1'b1;
            coz_durdur = 1'b1;
            yrt_bosalt = 1'b1;
            durum_d    = YUK_BEKLE;
          end
        end
        YUK_BEKLE: durum_d = CALIS;
        COK_CEVRIM: begin
          if (bus.yrt_cok_cevrim_bitti_i) begin
            durum_d = CALIS;
          end else if (zs_q == SON_SAYI) begin
            zaman_kur = 1'b1;
            durum_d   = CALIS;
          end else begin
            gtr_durdur = 1'b1;
            coz_durdur = 1'b1;
            yrt_durdur = 1'b1;
            zs_artir   = 1'b1;
          end
        end
        default: durum_d = CALIS;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (!rst_ni) begin
      durum_q        <= CALIS;
      zs_q           <= 8'd0;
      zaman_asimi_q  <= 1'b0;
      durdur_sayac_q <= 32'd0;
    end else begin
      durum_q <= durum_d;
      if (zs_sifirla)    zs_q <= 8'd0;
      else if (zs_artir) zs_q <= zs_q + 8'd1;
      if (zaman_kur)     zaman_asimi_q <= 1'b1;
      if (coz_durdur && (durdur_sayac_q != 32'hFFFF_FFFF))
        durdur_sayac_q <= durdur_sayac_q + 32'd1;
    end
  end

  assign bus.gtr_durdur_o   = gtr_durdur;
  assign bus.coz_durdur_o   = coz_durdur;
  assign bus.yrt_durdur_o   = yrt_durdur;
  assign bus.gtr_bosalt_o   = gtr_bosalt;
  assign bus.coz_bosalt_o   = coz_bosalt;
  assign bus.yrt_bosalt_o   = yrt_bosalt;
  assign bus.durum_o        = durum_q;
  assign bus.zaman_asimi_o  = zaman_asimi_q;
  assign bus.durdur_sayac_o = durdur_sayac_q;

endmodule

// File: tb/tb_denetim_durum_birimi.sv
// Scoreboard bench for denetim_durum_birimi: stimulus pushes the reference
// model's expected response each cycle, a negedge monitor pops and compares.
module tb_denetim_durum_birimi;

  localparam int ZA = 40;

  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic       k1, k2;
    logic [4:0] yrt_rd;
    logic       yrt_yaz, yrt_oku;
    logic [4:0] gy_rd;
    logic       gy_yaz;
    logic       basla, bitti, atlama, bekle;
  } girdi_t;

  typedef struct packed {
    logic [1:0]  f1, f2;
    logic        gd, cd, yd, gb, cb, yb;
    logic [1:0]  durum;
    logic        zaman;
    logic [31:0] sayac;
  } beklenen_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  denetim_durum_birimi_if bus();

  denetim_durum_birimi #(.ZAMAN_ASIMI(ZA)) u_dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int toplam = 0;
  int hatali = 0;
  int yrt_durdur_gozlem = 0;
  beklenen_t sb_q[$];

  // Reference model state
  bit          m_cok, m_yuk, m_zaman;
  int          m_gecen;
  longint      m_sayac;

  task automatic check(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    toplam++;
    if (gercek !== beklenen) begin
      hatali++;
      $display("FAIL %s gercek=%0h beklenen=%0h t=%0t", ad, gercek, beklenen, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input girdi_t g);
    if (g.yrt_yaz && g.yrt_rd != 0 && g.yrt_rd == rs && !g.yrt_oku) return 2'b01;
    if (g.gy_yaz && g.gy_rd != 0 && g.gy_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic sur_bus(input girdi_t g);
    bus.coz_rs1_adres_i        = g.rs1;
    bus.coz_rs2_adres_i        = g.rs2;
    bus.coz_rs1_kullan_i       = g.k1;
    bus.coz_rs2_kullan_i       = g.k2;
    bus.yrt_rd_adres_i         = g.yrt_rd;
    bus.yrt_yaz_yazmac_i       = g.yrt_yaz;
    bus.yrt_bellek_oku_i       = g.yrt_oku;
    bus.gy_rd_adres_i          = g.gy_rd;
    bus.gy_yaz_yazmac_i        = g.gy_yaz;
    bus.yrt_cok_cevrim_basla_i = g.basla;
    bus.yrt_cok_cevrim_bitti_i = g.bitti;
    bus.yrt_atlama_i           = g.atlama;
    bus.bellek_bekle_i         = g.bekle;
  endtask

  // One clock of stimulus: drive, predict from the rules, advance the model.
  task automatic sur(input girdi_t g);
    beklenen_t e;
    bit yu;
    @(posedge clk);
    #1;
    sur_bus(g);
    e = '0;
    e.f1    = ref_fwd(g.rs1, g);
    e.f2    = ref_fwd(g.rs2, g);
    e.durum = m_cok ? 2'b10 : (m_yuk ? 2'b01 : 2'b00);
    e.zaman = m_zaman;
    e.sayac = m_sayac[31:0];
    yu = g.yrt_oku && g.yrt_yaz && g.yrt_rd != 0 &&
         ((g.k1 && g.yrt_rd == g.rs1) || (g.k2 && g.yrt_rd == g.rs2));
    if (g.bekle) begin
      e.gd = 1; e.cd = 1; e.yd = 1;
    end else begin
      e.gb = g.atlama;
      e.cb = g.atlama;
      if (m_cok) begin
        if (g.bitti) m_cok = 0;
        else if (m_gecen == ZA - 1) begin m_zaman = 1; m_cok = 0; end
        else begin e.gd = 1; e.cd = 1; e.yd = 1; m_gecen++; end
      end else if (m_yuk) begin
        m_yuk = 0;
      end else if (g.basla) begin
        m_cok = 1; m_gecen = 0;
      end else if (yu && !g.atlama) begin
        e.gd = 1; e.cd = 1; e.yb = 1; m_yuk = 1;
      end
    end
    if (e.cd && m_sayac < 64'hFFFF_FFFF) m_sayac++;
    sb_q.push_back(e);
  endtask

  task automatic bosalt_bekle();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    beklenen_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("yonlendir1", 32'(bus.yonlendir_kontrol1_o), 32'(e.f1));
      check("yonlendir2", 32'(bus.yonlendir_kontrol2_o), 32'(e.f2));
      check("gtr_durdur", 32'(bus.gtr_durdur_o), 32'(e.gd));
      check("coz_durdur", 32'(bus.coz_durdur_o), 32'(e.cd));
      check("yrt_durdur", 32'(bus.yrt_durdur_o), 32'(e.yd));
      check("gtr_bosalt", 32'(bus.gtr_bosalt_o), 32'(e.gb));
      check("coz_bosalt", 32'(bus.coz_bosalt_o), 32'(e.cb));
      check("yrt_bosalt", 32'(bus.yrt_bosalt_o), 32'(e.yb));
      check("durum",      32'(bus.durum_o), 32'(e.durum));
      check("zaman_asimi", 32'(bus.zaman_asimi_o), 32'(e.zaman));
      check("durdur_sayac", bus.durdur_sayac_o, e.sayac);
      if (bus.yrt_durdur_o) yrt_durdur_gozlem++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog zaman=%0t siniri=100000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    girdi_t g;
    g = '0;
    sur_bus(g);
    #3;
    check("reset_durum", 32'(bus.durum_o), 32'd0);
    check("reset_sayac", bus.durdur_sayac_o, 32'd0);
    check("reset_zaman", 32'(bus.zaman_asimi_o), 32'd0);
    check("reset_durdur", 32'({bus.gtr_durdur_o, bus.coz_durdur_o, bus.yrt_durdur_o}), 32'd0);
    check("reset_fwd", 32'({bus.yonlendir_kontrol1_o, bus.yonlendir_kontrol2_o}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_ni = 1'b1;

    // Forwarding priority: YURUT over GERIYAZ, x0 never forwarded, GERIYAZ only.
    g = '0; g.yrt_rd = 5; g.yrt_yaz = 1; g.gy_rd = 5; g.gy_yaz = 1; g.rs1 = 5; g.k1 = 1;
    sur(g);
    g = '0; g.yrt_rd = 0; g.yrt_yaz = 1; g.rs1 = 0; g.k1 = 1;
    sur(g);
    g = '0; g.gy_rd = 9; g.gy_yaz = 1; g.rs1 = 9; g.rs2 = 9;
    sur(g);

    // Load-use: LW rd=7 in YURUT, rs2=7 used in COZ; then the load is in GERIYAZ.
    g = '0; g.yrt_rd = 7; g.yrt_yaz = 1; g.yrt_oku = 1; g.rs2 = 7; g.k2 = 1;
    sur(g);
    g = '0; g.gy_rd = 7; g.gy_yaz = 1; g.rs2 = 7; g.k2 = 1;
    sur(g);
    g = '0;
    sur(g);

    // Load-use together with a taken jump: flush only.
    g = '0; g.yrt_rd = 3; g.yrt_yaz = 1; g.yrt_oku = 1; g.rs1 = 3; g.k1 = 1; g.atlama = 1;
    sur(g);
    g = '0;
    sur(g);

    // Multi-cycle: bitti 34 cycles after basla.
    bosalt_bekle();
    yrt_durdur_gozlem = 0;
    g = '0; g.basla = 1; sur(g);
    g = '0;
    for (int i = 0; i < 33; i++) sur(g);
    g.bitti = 1; sur(g);
    g = '0; sur(g);
    bosalt_bekle();
    check("cok_cevrim_durdur_adet", 32'(yrt_durdur_gozlem), 32'd33);

    // Memory wait during COK_CEVRIM with bitti in the middle of it.
    g = '0; g.basla = 1; sur(g);
    g = '0;
    for (int i = 0; i < 3; i++) sur(g);
    g.bekle = 1; sur(g);
    g.bitti = 1; sur(g);
    g.bitti = 0; sur(g);
    g = '0; sur(g); sur(g);
    g.bitti = 1; sur(g);
    g = '0; sur(g);

    // Timeout: no bitti, ZA-1 stall cycles then forced exit.
    bosalt_bekle();
    yrt_durdur_gozlem = 0;
    g = '0; g.basla = 1; sur(g);
    g = '0;
    for (int i = 0; i < ZA + 5; i++) sur(g);
    bosalt_bekle();
    check("zaman_asimi_durdur_adet", 32'(yrt_durdur_gozlem), 32'(ZA - 1));
    check("zaman_asimi_bayrak", 32'(bus.zaman_asimi_o), 32'd1);

    // Asynchronous reset in the middle of COK_CEVRIM.
    g = '0; g.basla = 1; sur(g);
    g = '0;
    for (int i = 0; i < 5; i++) sur(g);
    bosalt_bekle();
    check("oncesi_durum", 32'(bus.durum_o), 32'd2);
    rst_ni = 1'b0;
    #1;
    check("async_reset_durum", 32'(bus.durum_o), 32'd0);
    check("async_reset_sayac", bus.durdur_sayac_o, 32'd0);
    check("async_reset_zaman", 32'(bus.zaman_asimi_o), 32'd0);
    check("async_reset_durdur", 32'({bus.gtr_durdur_o, bus.coz_durdur_o, bus.yrt_durdur_o}), 32'd0);
    m_cok = 0; m_yuk = 0; m_zaman = 0; m_gecen = 0; m_sayac = 0;
    @(posedge clk);
    #1 rst_ni = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      bit bos;
      bos = !m_cok && !m_yuk;
      g.rs1     = 5'($urandom_range(0, 7));
      g.rs2     = 5'($urandom_range(0, 7));
      g.k1      = 1'($urandom_range(0, 1));
      g.k2      = 1'($urandom_range(0, 1));
      g.yrt_rd  = 5'($urandom_range(0, 7));
      g.yrt_yaz = 1'($urandom_range(0, 1));
      g.yrt_oku = 1'($urandom_range(0, 2) == 0);
      g.gy_rd   = 5'($urandom_range(0, 7));
      g.gy_yaz  = 1'($urandom_range(0, 1));
      g.basla   = bos && ($urandom_range(0, 9) == 0);
      g.atlama  = bos && !g.basla && ($urandom_range(0, 7) == 0);
      g.bitti   = m_cok && ($urandom_range(0, 5) == 0);
      g.bekle   = ($urandom_range(0, 7) == 0);
      sur(g);
    end
    g = '0;
    sur(g);
    bosalt_bekle();
    check("skor_kuyrugu_bos", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", toplam, hatali);
    $finish;
  end

endmodule
